// File: rtl/stage5mo.sv
// Memory-operation stage: issues LD/LDi/ST/STi data-memory transactions over a
// req/ready handshake, stalls while busy, and forwards a registered bundle to write-back.
module stage5mo #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DATA_W         = 24,
    localparam int unsigned FLAGS_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_in,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  instr_in,
    input  logic [DATA_W-1:0]  result_in,
    input  logic [DATA_W-1:0]  store_data_in,
    input  logic [FLAGS_W-1:0] flags_in,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ready,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall_out,
    output logic               mem_fault,
    output logic               enable_out,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  instr_out,
    output logic [DATA_W-1:0]  result_out,
    output logic [FLAGS_W-1:0] flags_out
);

    localparam int unsigned OPC_W = 8;
    localparam int unsigned CNT_W = 8;

    // Memory opcodes of the ISA (opcode field is instr[23:16])
    localparam logic [OPC_W-1:0] OPC_R_LD  = 8'h10;
    localparam logic [OPC_W-1:0] OPC_R_ST  = 8'h11;
    localparam logic [OPC_W-1:0] OPC_I_LDi = 8'h20;
    localparam logic [OPC_W-1:0] OPC_I_STi = 8'h21;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [0:0]         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic [DATA_W-1:0]  hold_pc, hold_pc_nx;
    logic [DATA_W-1:0]  hold_instr, hold_instr_nx;
    logic [DATA_W-1:0]  hold_result, hold_result_nx;
    logic [FLAGS_W-1:0] hold_flags, hold_flags_nx;

    logic               mem_req_nx;
    logic               mem_we_nx;
    logic [DATA_W-1:0]  mem_addr_nx;
    logic [DATA_W-1:0]  mem_wdata_nx;
    logic               stall_out_nx;
    logic               mem_fault_nx;
    logic               enable_out_nx;
    logic [DATA_W-1:0]  pc_out_nx;
    logic [DATA_W-1:0]  instr_out_nx;
    logic [DATA_W-1:0]  result_out_nx;
    logic [FLAGS_W-1:0] flags_out_nx;

    logic [OPC_W-1:0]   opc_c;
    logic               is_load_c;
    logic               is_store_c;

    // Opcode decode of the incoming instruction
    assign opc_c      = instr_in[DATA_W-1 -: OPC_W];
    assign is_load_c  = (opc_c == OPC_R_LD) || (opc_c == OPC_I_LDi);
    assign is_store_c = (opc_c == OPC_R_ST) || (opc_c == OPC_I_STi);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_pc     <= '0;
            hold_instr  <= '0;
            hold_result <= '0;
            hold_flags  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            stall_out   <= 1'b0;
            mem_fault   <= 1'b0;
            enable_out  <= 1'b0;
            pc_out      <= '0;
            instr_out   <= '0;
            result_out  <= '0;
            flags_out   <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            hold_pc     <= hold_pc_nx;
            hold_instr  <= hold_instr_nx;
            hold_result <= hold_result_nx;
            hold_flags  <= hold_flags_nx;
            mem_req     <= mem_req_nx;
            mem_we      <= mem_we_nx;
            mem_addr    <= mem_addr_nx;
            mem_wdata   <= mem_wdata_nx;
            stall_out   <= stall_out_nx;
            mem_fault   <= mem_fault_nx;
            enable_out  <= enable_out_nx;
            pc_out      <= pc_out_nx;
            instr_out   <= instr_out_nx;
            result_out  <= result_out_nx;
            flags_out   <= flags_out_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        hold_pc_nx     = hold_pc;
        hold_instr_nx  = hold_instr;
        hold_result_nx = hold_result;
        hold_flags_nx  = hold_flags;
        mem_req_nx     = mem_req;
        mem_we_nx      = mem_we;
        mem_addr_nx    = mem_addr;
        mem_wdata_nx   = mem_wdata;
        mem_fault_nx   = mem_fault;
        enable_out_nx  = 1'b0;
        pc_out_nx      = pc_out;
        instr_out_nx   = instr_out;
        result_out_nx  = result_out;
        flags_out_nx   = flags_out;

        case (state)
            IDLE: begin
                if (enable_in) begin
                    if (is_load_c || is_store_c) begin
                        state_nx       = BUSY;
                        cnt_nx         = '0;
                        mem_req_nx     = 1'b1;
                        mem_we_nx      = is_store_c;
                        mem_addr_nx    = result_in;
                        mem_wdata_nx   = is_store_c ? store_data_in : '0;
                        hold_pc_nx     = pc_in;
                        hold_instr_nx  = instr_in;
                        hold_result_nx = result_in;
                        hold_flags_nx  = flags_in;
                    end else begin
                        enable_out_nx  = 1'b1;
                        pc_out_nx      = pc_in;
                        instr_out_nx   = instr_in;
                        result_out_nx  = result_in;
                        flags_out_nx   = flags_in;
                    end
                end
            end
            BUSY: begin
                // A ready in the final timeout cycle still completes normally
                if (mem_ready || (cnt == CNT_LAST)) begin
                    state_nx      = IDLE;
                    mem_req_nx    = 1'b0;
                    enable_out_nx = 1'b1;
                    pc_out_nx     = hold_pc;
                    instr_out_nx  = hold_instr;
                    flags_out_nx  = hold_flags;
                    if (!mem_ready) begin
                        mem_fault_nx  = 1'b1;
                        result_out_nx = '0;
                    end else begin
                        result_out_nx = mem_we ? hold_result : mem_rdata;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase

        stall_out_nx = (state_nx == BUSY);
    end

endmodule

// File: tb/tb_stage5mo.sv
// Directed bench for stage5mo: pass-through, load/store handshakes, timeout and reset cases.
module tb_stage5mo;

    localparam logic [7:0] OPC_ADD = 8'h01;
    localparam logic [7:0] OPC_LD  = 8'h10;
    localparam logic [7:0] OPC_ST  = 8'h11;
    localparam logic [7:0] OPC_LDI = 8'h20;
    localparam logic [7:0] OPC_STI = 8'h21;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic [23:0] pc_in, instr_in, result_in, store_data_in;
    logic [3:0]  flags_in;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [23:0] mem_rdata;
    logic        stall_out, mem_fault, enable_out;
    logic [23:0] pc_out, instr_out, result_out;
    logic [3:0]  flags_out;

    int n_tests = 0;
    int n_fail  = 0;

    stage5mo #(.TIMEOUT_CYCLES(4), .DATA_W(24)) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
        .result_in(result_in), .store_data_in(store_data_in), .flags_in(flags_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_out(stall_out),
        .mem_fault(mem_fault), .enable_out(enable_out), .pc_out(pc_out),
        .instr_out(instr_out), .result_out(result_out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] opc, input logic [23:0] pc, input logic [23:0] res,
                         input logic [23:0] sdata, input logic [3:0] fl);
        enable_in     = 1'b1;
        instr_in      = {opc, 16'h0055};
        pc_in         = pc;
        result_in     = res;
        store_data_in = sdata;
        flags_in      = fl;
    endtask

    task automatic idle_inputs();
        enable_in     = 1'b0;
        instr_in      = 24'hFFFFFF;
        pc_in         = 24'hDEAD00;
        result_in     = 24'h0BAD00;
        store_data_in = 24'h777777;
        flags_in      = 4'hF;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        enable_in     = 1'b1;
        instr_in      = {OPC_LD, 16'($urandom)};
        pc_in         = 24'($urandom);
        result_in     = 24'($urandom);
        store_data_in = 24'($urandom);
        flags_in      = 4'($urandom);
        mem_ready     = 1'($urandom);
        mem_rdata     = 24'($urandom);
        tick();
        tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out, mem_fault} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_mem_side got req=%b we=%b addr=%h wdata=%h stall=%b fault=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, stall_out, mem_fault);
        end
        n_tests++;
        if ({enable_out, pc_out, instr_out, result_out, flags_out} !== 77'd0) begin
            n_fail++;
            $display("FAIL reset_bundle got en=%b pc=%h instr=%h res=%h flags=%h want all 0",
                     enable_out, pc_out, instr_out, result_out, flags_out);
        end
        idle_inputs();
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({enable_out, mem_req, stall_out, result_out} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_release got en=%b req=%b stall=%b res=%h want 0",
                     enable_out, mem_req, stall_out, result_out);
        end
    endtask

    task automatic test_passthrough();
        issue(OPC_ADD, 24'h000010, 24'h00ABCD, 24'h000000, 4'h5);
        tick();
        idle_inputs();
        n_tests++;
        if ({enable_out, pc_out, result_out, instr_out, flags_out} !== {1'b1, 24'h000010, 24'h00ABCD, OPC_ADD, 16'h0055, 4'h5}) begin
            n_fail++;
            $display("FAIL passthrough_bundle got en=%b pc=%h res=%h instr=%h flags=%h want 1 000010 00abcd 010055 5",
                     enable_out, pc_out, result_out, instr_out, flags_out);
        end
        n_tests++;
        if ({mem_req, stall_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL passthrough_no_req got req=%b stall=%b want 0 0", mem_req, stall_out);
        end
        tick();
        n_tests++;
        if ({enable_out, result_out, mem_req} !== {1'b0, 24'h00ABCD, 1'b0}) begin
            n_fail++;
            $display("FAIL passthrough_hold got en=%b res=%h req=%b want 0 00abcd 0", enable_out, result_out, mem_req);
        end
    endtask

    task automatic test_load_wait();
        mem_ready = 1'b0;
        issue(OPC_LD, 24'h000020, 24'h000400, 24'h000999, 4'h3);
        tick();
        idle_inputs();
        enable_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out, enable_out} !== {1'b1, 1'b0, 24'h000400, 24'h000000, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL load_wait_c%0d got req=%b we=%b addr=%h wdata=%h stall=%b en=%b want 1 0 000400 000000 1 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, stall_out, enable_out);
            end
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 24'h123456;
        n_tests++;
        if ({mem_req, stall_out, enable_out} !== 3'b110) begin
            n_fail++;
            $display("FAIL load_wait_c3 got req=%b stall=%b en=%b want 1 1 0", mem_req, stall_out, enable_out);
        end
        tick();
        mem_ready = 1'b0;
        enable_in = 1'b0;
        n_tests++;
        if ({enable_out, result_out, pc_out, flags_out, stall_out, mem_req, mem_fault} !== {1'b1, 24'h123456, 24'h000020, 4'h3, 3'b000}) begin
            n_fail++;
            $display("FAIL load_done got en=%b res=%h pc=%h flags=%h stall=%b req=%b fault=%b want 1 123456 000020 3 0 0 0",
                     enable_out, result_out, pc_out, flags_out, stall_out, mem_req, mem_fault);
        end
        tick();
        n_tests++;
        if ({enable_out, result_out} !== {1'b0, 24'h123456}) begin
            n_fail++;
            $display("FAIL load_single_pulse got en=%b res=%h want 0 123456", enable_out, result_out);
        end
    endtask

    task automatic test_store_zero_wait();
        mem_ready = 1'b1;
        issue(OPC_STI, 24'h000030, 24'h000020, 24'h00BEEF, 4'h9);
        tick();
        idle_inputs();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out, enable_out} !== {1'b1, 1'b1, 24'h000020, 24'h00BEEF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h stall=%b en=%b want 1 1 000020 00beef 1 0",
                     mem_req, mem_we, mem_addr, mem_wdata, stall_out, enable_out);
        end
        tick();
        n_tests++;
        if ({enable_out, result_out, pc_out, mem_req, stall_out} !== {1'b1, 24'h000020, 24'h000030, 2'b00}) begin
            n_fail++;
            $display("FAIL store_done got en=%b res=%h pc=%h req=%b stall=%b want 1 000020 000030 0 0",
                     enable_out, result_out, pc_out, mem_req, stall_out);
        end
        tick();
        n_tests++;
        if ({enable_out, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_idle_ready got en=%b req=%b want 0 0", enable_out, mem_req);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_store_wait();
        mem_ready = 1'b0;
        issue(OPC_ST, 24'h000044, 24'h000800, 24'h001234, 4'h1);
        tick();
        idle_inputs();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 24'hAAAAAA;
        tick();
        mem_ready = 1'b0;
        n_tests++;
        if ({enable_out, result_out, mem_fault} !== {1'b1, 24'h000800, 1'b0}) begin
            n_fail++;
            $display("FAIL store_wait_done got en=%b res=%h fault=%b want 1 000800 0", enable_out, result_out, mem_fault);
        end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        issue(OPC_LD, 24'h000040, 24'h000500, 24'h000000, 4'h6);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({mem_req, mem_fault, enable_out} !== 3'b100) begin
                n_fail++;
                $display("FAIL timeout_busy_c%0d got req=%b fault=%b en=%b want 1 0 0", i, mem_req, mem_fault, enable_out);
            end
            tick();
        end
        n_tests++;
        if ({mem_req, mem_fault, enable_out, result_out, pc_out, stall_out} !== {3'b011, 24'h000000, 24'h000040, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_abort got req=%b fault=%b en=%b res=%h pc=%h stall=%b want 0 1 1 000000 000040 0",
                     mem_req, mem_fault, enable_out, result_out, pc_out, stall_out);
        end
        issue(OPC_ADD, 24'h000050, 24'h000777, 24'h000000, 4'h2);
        tick();
        idle_inputs();
        n_tests++;
        if ({enable_out, result_out, mem_fault} !== {1'b1, 24'h000777, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_sticky got en=%b res=%h fault=%b want 1 000777 1", enable_out, result_out, mem_fault);
        end
    endtask

    task automatic test_timeout_ready_last();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_ready = 1'b0;
        issue(OPC_LDI, 24'h000060, 24'h000600, 24'h000000, 4'h4);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b1;
        mem_rdata = 24'hA5A5A5;
        tick();
        mem_ready = 1'b0;
        n_tests++;
        if ({enable_out, result_out, mem_fault, mem_req} !== {1'b1, 24'hA5A5A5, 2'b00}) begin
            n_fail++;
            $display("FAIL ready_last_cycle got en=%b res=%h fault=%b req=%b want 1 a5a5a5 0 0",
                     enable_out, result_out, mem_fault, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        issue(OPC_ADD, 24'h000070, 24'h000111, 24'h000000, 4'h0);
        tick();
        n_tests++;
        if ({enable_out, result_out} !== {1'b1, 24'h000111}) begin
            n_fail++;
            $display("FAIL b2b_first got en=%b res=%h want 1 000111", enable_out, result_out);
        end
        issue(OPC_ADD, 24'h000074, 24'h000222, 24'h000000, 4'h0);
        tick();
        idle_inputs();
        n_tests++;
        if ({enable_out, result_out, pc_out} !== {1'b1, 24'h000222, 24'h000074}) begin
            n_fail++;
            $display("FAIL b2b_second got en=%b res=%h pc=%h want 1 000222 000074", enable_out, result_out, pc_out);
        end
        tick();
        n_tests++;
        if (enable_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got en=%b want 0", enable_out);
        end
    endtask

    task automatic test_reset_mid_op();
        mem_ready = 1'b0;
        issue(OPC_LD, 24'h000080, 24'h000700, 24'h000000, 4'h8);
        tick();
        idle_inputs();
        tick();
        n_tests++;
        if ({mem_req, stall_out} !== 2'b11) begin
            n_fail++;
            $display("FAIL midop_busy got req=%b stall=%b want 1 1", mem_req, stall_out);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if ({mem_req, stall_out, enable_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL midop_reset got req=%b stall=%b en=%b want 0 0 0", mem_req, stall_out, enable_out);
        end
        mem_ready = 1'b1;
        mem_rdata = 24'hFFFFFF;
        tick();
        mem_ready = 1'b0;
        tick();
        n_tests++;
        if ({enable_out, mem_req, result_out, pc_out} !== {2'b00, 24'h000000, 24'h000000}) begin
            n_fail++;
            $display("FAIL midop_ready_ignored got en=%b req=%b res=%h pc=%h want 0 0 000000 000000",
                     enable_out, mem_req, result_out, pc_out);
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        test_reset();
        test_passthrough();
        test_load_wait();
        test_store_zero_wait();
        test_store_wait();
        test_timeout();
        test_timeout_ready_last();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage5mo.md
Name: stage5mo

Overview:
Memory-operation stage, directly downstream of the memory-address stage. It takes the latched pc/instr/result/store_data/flags bundle and performs the data-memory transaction for load and store opcodes over a req/ready handshake. It stalls the pipeline while a transaction is outstanding, then forwards a registered bundle to write-back; for loads, the result field carries the read data. Non-memory instructions pass through with 1-cycle latency.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles with mem_req high and no mem_ready before the transaction is aborted (1..255)
DATA_W, 24, data and address width; fixed by the ISA

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset: synchronous, active-low
enable_in  in  1  upstream bundle valid this cycle
pc_in  in  24  PC from address stage (already branch-resolved)
instr_in  in  24  instruction; opcode = instr_in[23:16]
result_in  in  24  ALU result; the memory address for LD/LDi/ST/STi
store_data_in  in  24  store data
flags_in  in  4  flags
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write (ST/STi), 0 = read, registered
mem_addr  out  24  memory address, registered
mem_wdata  out  24  write data, registered
mem_ready  in  1  memory accepts/completes the request this cycle
mem_rdata  in  24  read data, valid when mem_ready=1 on a read
stall_out  out  1  1 = stage busy; pipeline control must hold enable_in low
mem_fault  out  1  sticky timeout flag
enable_out  out  1  one-cycle pulse: output bundle valid
pc_out  out  24  registered PC
instr_out  out  24  registered instruction
result_out  out  24  load data for loads, result_in otherwise
flags_out  out  4  registered flags

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE; all outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, stall_out, mem_fault, enable_out and the bundle; timeout counter 0. Reset during BUSY drops mem_req at that edge, and the transaction is discarded with no enable_out.
- Memory opcodes: `OPC_R_LD`, `OPC_I_LDi` (read) and `OPC_R_ST`, `OPC_I_STi` (write), taken from opcodes.vh.
- States: IDLE, BUSY.
- IDLE, enable_in=1, non-memory opcode: on the next edge, latch the bundle (result_out=result_in) and set enable_out=1 for exactly 1 cycle. Stay in IDLE.
- IDLE, enable_in=1, memory opcode: on the next edge, go to BUSY with mem_req=1, mem_we set per opcode, mem_addr=result_in, mem_wdata=store_data_in (0 for reads). Hold pc/instr/result/flags internally.
- BUSY: mem_req/we/addr/wdata stay stable until transfer. stall_out = 1 (registered, equal to state==BUSY). enable_in and all bundle inputs are ignored.
- Transfer occurs when mem_req=1 and mem_ready=1 at a rising edge. On that edge:
  - mem_req goes to 0 and the state returns to IDLE.
  - Output bundle latches the held values; result_out = mem_rdata for reads, held result for writes.
  - enable_out pulses for 1 cycle.
- Minimum memory latency: 2 cycles from the accepting edge to enable_out (ready already high in the first BUSY cycle).
- Timeout: the counter increments each BUSY cycle without mem_ready and resets on entry to BUSY. When it reaches TIMEOUT_CYCLES:
  - mem_req drops and mem_fault is set (sticky until reset).
  - The bundle completes with result_out=0 and enable_out pulses once.
  - State returns to IDLE.
  - mem_ready in that same cycle takes priority: normal transfer, no fault.
- enable_out never asserts in two consecutive cycles for memory ops. Back-to-back non-memory instructions give consecutive pulses.
- mem_ready while IDLE is ignored.
- Outputs hold their values when enable_out=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> every output 0. Release -> stays 0 until enable_in.
- Pass-through: ADD instr (non-memory), result_in=0x00ABCD, pc_in=0x000010, enable_in=1 for 1 cycle -> next cycle enable_out=1, result_out=0x00ABCD, pc_out=0x000010, mem_req never 1.
- Load with wait: LD, result_in=0x000400; mem_ready held low 3 cycles, then high with mem_rdata=0x123456 -> mem_req=1, mem_we=0, mem_addr=0x000400, stall_out=1 for 4 cycles; then result_out=0x123456, enable_out one pulse, stall_out=0.
- Store zero-wait: STi, result_in=0x000020, store_data_in=0x00BEEF, mem_ready tied 1 -> mem_we=1, mem_wdata=0x00BEEF for 1 cycle; enable_out 2 cycles after accept, result_out=0x000020.
- Timeout: TIMEOUT_CYCLES=4, LD, mem_ready=0 -> after 4 BUSY cycles mem_req=0, mem_fault=1, enable_out pulse with result_out=0. Next ADD passes normally and mem_fault stays 1. A repeat run with mem_ready=1 on the 4th cycle -> transfer, no fault.
- Reset mid-op: LD in BUSY, rst=0 for 1 cycle -> mem_req=0 and stall_out=0 at that edge; no enable_out; a later mem_ready pulse is ignored.
